// File: rtl/serdes_pkg.sv
// Shared definitions for the serial/parallel converters.
// Bit-order modes and counter width helper.
package serdes_pkg;

  localparam int LSB_FIRST_MODE = 1;
  localparam int MSB_FIRST_MODE = 0;

  function automatic int cnt_width(input int w);
    int c;
    c = $clog2(w);
    return (c < 1) ? 1 : c;
  endfunction

endpackage

// File: rtl/sipo_shift_core.sv
// Shift register and bit counter for the SIPO deserializer.
// Offers the completed word combinationally on its last bit.
module sipo_shift_core
  import serdes_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int LSB_FIRST = LSB_FIRST_MODE,
  parameter int CNT_W     = cnt_width(WIDTH)
) (
  input  logic             clkIn,
  input  logic             rst,
  input  logic             din,
  input  logic             dinValid,
  input  logic             frameStart,
  output logic [CNT_W-1:0] bitCount,
  output logic             wordDone,
  output logic [WIDTH-1:0] wordData
);

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_next;

  always_comb begin
    if (LSB_FIRST == LSB_FIRST_MODE)
      sr_next = {din, sr[WIDTH-1:1]};
    else
      sr_next = {sr[WIDTH-2:0], din};
  end

  assign wordData = sr_next;
  assign wordDone = dinValid && !frameStart &&
                    (bitCount == LAST);

  always_ff @(posedge clkIn) begin
    if (rst) begin
      sr       <= '0;
      bitCount <= '0;
    end else if (dinValid) begin
      sr <= sr_next;
      // frameStart makes this bit the first of a word
      if (frameStart)
        bitCount <= CNT_W'(1);
      else if (bitCount == LAST)
        bitCount <= '0;
      else
        bitCount <= bitCount + 1'b1;
    end
  end

endmodule

// File: rtl/sipo_framed_deserializer.sv
// Framed serial-to-parallel converter with output holding
// register, valid/ready handshake and sticky overrun.
module sipo_framed_deserializer
  import serdes_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int LSB_FIRST = LSB_FIRST_MODE,
  parameter int CNT_W     = cnt_width(WIDTH)
) (
  input  logic             clkIn,
  input  logic             rst,
  input  logic             din,
  input  logic             dinValid,
  input  logic             frameStart,
  output logic [WIDTH-1:0] dout,
  output logic             doutValid,
  input  logic             doutReady,
  output logic             overrun,
  input  logic             clrOverrun,
  output logic [CNT_W-1:0] bitCount
);

  logic             word_done;
  logic [WIDTH-1:0] word_data;
  logic             load;
  logic             drop;

  sipo_shift_core #(
    .WIDTH     (WIDTH),
    .LSB_FIRST (LSB_FIRST),
    .CNT_W     (CNT_W)
  ) u_core (
    .clkIn      (clkIn),
    .rst        (rst),
    .din        (din),
    .dinValid   (dinValid),
    .frameStart (frameStart),
    .bitCount   (bitCount),
    .wordDone   (word_done),
    .wordData   (word_data)
  );

  assign load = word_done && (!doutValid || doutReady);
  assign drop = word_done && doutValid && !doutReady;

  always_ff @(posedge clkIn) begin
    if (rst) begin
      dout      <= '0;
      doutValid <= 1'b0;
    end else if (load) begin
      dout      <= word_data;
      doutValid <= 1'b1;
    end else if (doutValid && doutReady) begin
      doutValid <= 1'b0;
    end
  end

  // a new overrun beats a simultaneous clear
  always_ff @(posedge clkIn) begin
    if (rst)
      overrun <= 1'b0;
    else if (drop)
      overrun <= 1'b1;
    else if (clrOverrun)
      overrun <= 1'b0;
  end

endmodule

// File: tb/tb_sipo_framed_deserializer.sv
// Directed bench for sipo_framed_deserializer, LSB- and
// MSB-first instances sharing one stimulus stream.
module tb_sipo_framed_deserializer;

  logic       clk = 1'b0;
  logic       rst;
  logic       din;
  logic       din_valid;
  logic       frame_start;
  logic       dout_ready;
  logic       clr_overrun;

  logic [3:0] l_dout, m_dout;
  logic       l_vld, m_vld;
  logic       l_ovr, m_ovr;
  logic [1:0] l_cnt, m_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  sipo_framed_deserializer #(
    .WIDTH(4), .LSB_FIRST(1)
  ) u_lsb (
    .clkIn(clk), .rst(rst), .din(din),
    .dinValid(din_valid), .frameStart(frame_start),
    .dout(l_dout), .doutValid(l_vld),
    .doutReady(dout_ready), .overrun(l_ovr),
    .clrOverrun(clr_overrun), .bitCount(l_cnt)
  );

  sipo_framed_deserializer #(
    .WIDTH(4), .LSB_FIRST(0)
  ) u_msb (
    .clkIn(clk), .rst(rst), .din(din),
    .dinValid(din_valid), .frameStart(frame_start),
    .dout(m_dout), .doutValid(m_vld),
    .doutReady(dout_ready), .overrun(m_ovr),
    .clrOverrun(clr_overrun), .bitCount(m_cnt)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got %0h want %0h",
               tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic send(input logic b,
                      input logic fs = 1'b0);
    din         = b;
    din_valid   = 1'b1;
    frame_start = fs;
    tick();
    din_valid   = 1'b0;
    frame_start = 1'b0;
  endtask

  initial begin
    rst = 1'b0; din = 1'b0; din_valid = 1'b0;
    frame_start = 1'b0; dout_ready = 1'b1;
    clr_overrun = 1'b0;

    do_reset();
    chk("rst_dout", l_dout, 4'h0);
    chk("rst_vld", l_vld, 1'b0);
    chk("rst_ovr", l_ovr, 1'b0);
    chk("rst_cnt", l_cnt, 2'd0);
    chk("rst_mcnt", m_cnt, 2'd0);

    // 1,0,1,1 back to back
    send(1); send(0); send(1);
    chk("b2b_cnt3", l_cnt, 2'd3);
    send(1);
    chk("b2b_lsb", l_dout, 4'b1101);
    chk("b2b_msb", m_dout, 4'b1011);
    chk("b2b_vld", l_vld, 1'b1);
    chk("b2b_cnt0", l_cnt, 2'd0);
    tick();
    chk("b2b_pulse", l_vld, 1'b0);
    chk("b2b_hold", l_dout, 4'b1101);

    // same bits with gaps
    send(1); tick();
    chk("gap_cnt1", m_cnt, 2'd1);
    send(0); tick();
    chk("gap_cnt2", m_cnt, 2'd2);
    send(1); tick();
    chk("gap_cnt3", m_cnt, 2'd3);
    chk("gap_novld", m_vld, 1'b0);
    send(1);
    chk("gap_msb", m_dout, 4'b1011);
    chk("gap_vld", m_vld, 1'b1);
    tick();

    // overrun: 5 then A with no consumer
    do_reset();
    dout_ready = 1'b0;
    send(1); send(0); send(1); send(0);
    chk("ovr_first", l_dout, 4'h5);
    send(0); send(1); send(0); send(1);
    chk("ovr_keep", l_dout, 4'h5);
    chk("ovr_set", l_ovr, 1'b1);
    chk("ovr_vld", l_vld, 1'b1);
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;
    chk("ovr_drain", l_vld, 1'b0);
    chk("ovr_sticky", l_ovr, 1'b1);
    clr_overrun = 1'b1;
    tick();
    clr_overrun = 1'b0;
    chk("ovr_clr", l_ovr, 1'b0);

    // consume and reload on the same edge
    do_reset();
    dout_ready = 1'b0;
    send(1); send(1); send(0); send(0);
    chk("bb_first", l_dout, 4'h3);
    send(0); send(1); send(1);
    dout_ready = 1'b1;
    send(0);
    chk("bb_new", l_dout, 4'h6);
    chk("bb_vld", l_vld, 1'b1);
    chk("bb_noovr", l_ovr, 1'b0);
    tick();
    chk("bb_done", l_vld, 1'b0);

    // frame resync
    do_reset();
    send(1);
    chk("fs_c1", l_cnt, 2'd1);
    send(1);
    chk("fs_c2", l_cnt, 2'd2);
    send(0, 1'b1);
    chk("fs_c3", l_cnt, 2'd1);
    send(0);
    chk("fs_c4", l_cnt, 2'd2);
    chk("fs_novld", l_vld, 1'b0);
    send(1);
    chk("fs_c5", l_cnt, 2'd3);
    send(1);
    chk("fs_c6", l_cnt, 2'd0);
    chk("fs_dout", l_dout, 4'b1100);
    chk("fs_vld", l_vld, 1'b1);
    tick();

    // reset mid-word with a word held
    do_reset();
    dout_ready = 1'b0;
    send(1); send(0); send(0); send(1);
    chk("mr_held", l_dout, 4'h9);
    send(1); send(1); send(1);
    chk("mr_cnt", l_cnt, 2'd3);
    do_reset();
    chk("mr_dout", l_dout, 4'h0);
    chk("mr_vld", l_vld, 1'b0);
    chk("mr_cnt0", l_cnt, 2'd0);
    chk("mr_ovr", l_ovr, 1'b0);
    dout_ready = 1'b1;
    send(0); send(0); send(1); send(1);
    chk("mr_word", l_dout, 4'hC);
    chk("mr_wvld", l_vld, 1'b1);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sipo_framed_deserializer.md
# sipo_framed_deserializer

Parametrised serial-to-parallel converter. It shifts a 1-bit stream into a WIDTH-bit word, LSB-first or MSB-first, and qualifies each bit with a strobe so that idle clocks do not shift. Completed words move into an output holding register with a valid/ready handshake. The block adds frame resynchronisation and sticky overrun detection, and is the front end for any serial link feeding parallel logic in the design.

## Interface
- WIDTH, default 4: word width in bits; legal range 2..64.
- LSB_FIRST, default 1: 1 means the first received bit lands in dout[0]; 0 means it lands in dout[WIDTH-1].
- CNT_W, default $clog2(WIDTH): width of bitCount; derived, never overridden.

Ports (clock and reset first):
- clkIn  in  1  sole clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- din  in  1  serial data bit.
- dinValid  in  1  din is a valid bit this cycle; no shift when low.
- frameStart  in  1  qualified by dinValid; the current bit is bit 0 of a new word.
- dout  out  WIDTH  assembled word; stable while doutValid=1.
- doutValid  out  1  holding register contains an unconsumed word.
- doutReady  in  1  consumer accepts dout when doutValid=1.
- overrun  out  1  sticky; a completed word was dropped.
- clrOverrun  in  1  clears overrun.
- bitCount  out  CNT_W  number of bits of the current partial word already received (0..WIDTH-1).

## Operation
- Reset (rst=1 at an edge): shift register=0, bitCount=0, dout=0, doutValid=0, overrun=0. Reset overrides every other input. A reset mid-word discards the partial word and any held word.
- Shift on dinValid=1:
  - LSB_FIRST=1: sr <= {din, sr[WIDTH-1:1]}.
  - LSB_FIRST=0: sr <= {sr[WIDTH-2:0], din}.
  - bitCount increments.
- dinValid=0: sr and bitCount hold. frameStart is ignored.
- frameStart=1 with dinValid=1: the partial word is discarded and bitCount is forced to 1. The sr contents are don't-care apart from the new bit. There is no overrun or error flag for a truncated word.
- Word completion: dinValid=1 with bitCount=WIDTH-1 and frameStart=0. The assembled word, including the current bit, is offered to the holding register and bitCount wraps to 0.
- Holding register load: the offered word is loaded and doutValid=1 when either of these holds:
  - doutValid=0;
  - doutValid=1 and doutReady=1 in the same cycle (the old word is consumed and the new one loaded back to back; doutValid stays 1).
- Overrun: word completes while doutValid=1 and doutReady=0.
  - The new word is dropped, dout keeps the old word, and overrun is set.
  - The shift path keeps running; the next word assembles normally.
- Consume: doutValid=1, doutReady=1, no completion that cycle. Result: doutValid=0; dout holds its last value.
- overrun: set on an overrun event; cleared by clrOverrun=1. If both occur in the same cycle, set wins.

## Timing
- Shift latency 1 clock: the bit sampled at edge k is reflected in sr/bitCount after edge k.
- Word latency: final bit sampled at edge k gives doutValid=1 and the new dout after edge k, a zero-cycle bubble.
- Sustained throughput is one bit per clock. With doutReady held high, no word is ever lost.
- The handshake completes on any edge where doutValid and doutReady are both 1. doutReady may be asserted while doutValid=0 without effect.
- No combinational path from any input to any output; all outputs are registered.

## Structure
- Shared package serdes_pkg:
  - localparams LSB_FIRST_MODE=1 and MSB_FIRST_MODE=0;
  - function cnt_width(w) returning max(1, $clog2(w)), used for CNT_W here and in the future PISO sibling.
- One sub-module, sipo_shift_core, containing the shift register, bitCount and the wordDone/wordData outputs.
- The top level holds the output register, the handshake and the overrun logic.

## Test plan
- WIDTH=4, LSB_FIRST=1, doutReady=1. Bits 1,0,1,1 on consecutive cycles gives dout=4'b1101 with a one-cycle doutValid pulse after the 4th edge.
- WIDTH=4, LSB_FIRST=0. Same bits give dout=4'b1011. Repeat with dinValid low every other cycle: same result, and bitCount holds across gaps.
- doutReady=0. Send 4'h5, then 4'hA (LSB_FIRST=1): dout stays 4'h5, overrun=1. Raise doutReady for one cycle and doutValid falls. clrOverrun gives overrun=0.
- doutValid=1 with doutReady=1 exactly on the completion edge of the next word: dout updates to the new word, doutValid stays 1, overrun stays 0.
- Send 2 bits, then frameStart with bits 0,0,1,1: dout=4'b1100 (LSB_FIRST=1), and bitCount sequence is 1,2,1,2,3,0.
- Assert rst after 3 bits with a word held: all outputs return to 0 on the next edge. A subsequent full word assembles correctly from bitCount=0.
